// File: rtl/ahb_gpio_pkg.sv
// Register map, AHB transfer encodings and register index type shared by the
// ahb_gpio_v2 peripheral and its sub-modules.
package ahb_gpio_pkg;

  typedef logic [2:0] ahb_gpio_addr_t;

  localparam logic [4:0] GPIO_DATA_OUT_OFS = 5'h00;
  localparam logic [4:0] GPIO_DATA_IN_OFS  = 5'h04;
  localparam logic [4:0] GPIO_DIR_OFS      = 5'h08;
  localparam logic [4:0] GPIO_IRQ_EN_OFS   = 5'h0C;
  localparam logic [4:0] GPIO_IRQ_STAT_OFS = 5'h10;
  localparam logic [4:0] GPIO_STATUS_OFS   = 5'h14;

  // Word indices as seen on HADDR[4:2]
  localparam ahb_gpio_addr_t GPIO_DATA_OUT_IDX = GPIO_DATA_OUT_OFS[4:2];
  localparam ahb_gpio_addr_t GPIO_DATA_IN_IDX  = GPIO_DATA_IN_OFS[4:2];
  localparam ahb_gpio_addr_t GPIO_DIR_IDX      = GPIO_DIR_OFS[4:2];
  localparam ahb_gpio_addr_t GPIO_IRQ_EN_IDX   = GPIO_IRQ_EN_OFS[4:2];
  localparam ahb_gpio_addr_t GPIO_IRQ_STAT_IDX = GPIO_IRQ_STAT_OFS[4:2];
  localparam ahb_gpio_addr_t GPIO_STATUS_IDX   = GPIO_STATUS_OFS[4:2];

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop input synchroniser plus an optional edge-detect flop giving
// per-bit rising-edge pulses; the edge flop exists only with AHB_GPIO_V2_IRQ_EN.
module gpio_in_sync
  import ahb_gpio_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

`ifdef AHB_GPIO_V2_IRQ_EN
  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
`else
  assign rise = '0;
`endif

endmodule

// File: rtl/ahb_gpio_v2.sv
// Zero-wait AHB-Lite GPIO slave with per-bit direction, parity generation and
// checking, sticky parity status; interrupts compiled in with AHB_GPIO_V2_IRQ_EN.
module ahb_gpio_v2
  import ahb_gpio_pkg::*;
#(
  parameter int GPIO_W = 16,
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  output logic              HREADYOUT,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  input  logic [GPIO_W:0]   GPIOIN,
  output logic [GPIO_W:0]   GPIOOUT,
  input  logic              PARITYSEL,
  output logic              PARITYERR,
  output logic              IRQ
);

  logic              access;
  logic              valid_q;
  logic              write_q;
  ahb_gpio_addr_t    addr_q;
  logic              wr_en;
  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] data_out;
  logic [GPIO_W-1:0] dir;
  logic              status;
  logic              parity_err;
  logic [GPIO_W:0]   sync;
  logic [GPIO_W:0]   rise;
  logic              bad;
  logic [GPIO_W-1:0] out_bits;
  logic [31:0]       rd_word;
  logic              unused_bits;

  assign HREADYOUT = 1'b1;
  assign access    = HSEL & HREADY &
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= access;
      if (access) begin
        write_q <= HWRITE;
        addr_q  <= HADDR[4:2];
      end
    end
  end

  assign wr_en = valid_q & write_q;
  assign wdata = HWDATA[GPIO_W-1:0];

  gpio_in_sync #(.W(GPIO_W + 1)) u_sync (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .din   (GPIOIN),
    .sync  (sync),
    .rise  (rise)
  );

  // Full-word check including the parity bit; PARITYSEL flips the expectation
  assign bad = (^sync) ^ PARITYSEL;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_out   <= '0;
      dir        <= '0;
      status     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (wr_en && addr_q == GPIO_DATA_OUT_IDX) data_out <= wdata;
      if (wr_en && addr_q == GPIO_DIR_IDX)      dir      <= wdata;
      status     <= bad | (status & ~(wr_en && addr_q == GPIO_STATUS_IDX && HWDATA[0]));
      parity_err <= bad;
    end
  end

  assign PARITYERR = parity_err;

`ifdef AHB_GPIO_V2_IRQ_EN
  logic [GPIO_W-1:0] irq_en;
  logic [GPIO_W-1:0] irq_stat;
  logic [GPIO_W-1:0] irq_stat_nxt;
  logic [GPIO_W-1:0] irq_clr;
  logic              irq_q;

  // A new edge is OR-ed in after the clear so it survives a same-cycle W1C
  always_comb begin
    irq_clr      = '0;
    if (wr_en && addr_q == GPIO_IRQ_STAT_IDX) irq_clr = wdata;
    irq_stat_nxt = (irq_stat & ~irq_clr) | (rise[GPIO_W-1:0] & ~dir & irq_en);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_en   <= '0;
      irq_stat <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && addr_q == GPIO_IRQ_EN_IDX) irq_en <= wdata;
      irq_stat <= irq_stat_nxt;
      irq_q    <= |irq_stat_nxt;
    end
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

  assign out_bits = data_out & dir;
  assign GPIOOUT  = {(^out_bits) ^ PARITYSEL, out_bits};

  always_comb begin
    rd_word = '0;
    case (addr_q)
      GPIO_DATA_OUT_IDX: rd_word[GPIO_W-1:0] = data_out;
      GPIO_DATA_IN_IDX:  rd_word[GPIO_W-1:0] = sync[GPIO_W-1:0];
      GPIO_DIR_IDX:      rd_word[GPIO_W-1:0] = dir;
`ifdef AHB_GPIO_V2_IRQ_EN
      GPIO_IRQ_EN_IDX:   rd_word[GPIO_W-1:0] = irq_en;
      GPIO_IRQ_STAT_IDX: rd_word[GPIO_W-1:0] = irq_stat;
`endif
      GPIO_STATUS_IDX:   rd_word[0] = status;
      default:           rd_word = '0;
    endcase
    HRDATA = '0;
    if (valid_q && !write_q) HRDATA = rd_word;
  end

  assign unused_bits = ^{HADDR, HTRANS, HWDATA, rise};

endmodule

// File: tb/tb_ahb_gpio_v2.sv
// Self-checking bench for ahb_gpio_v2: directed literal checks followed by
// randomized bus and GPIO traffic compared every cycle against a behavioural model.
module tb_ahb_gpio_v2;
  import ahb_gpio_pkg::*;

  localparam int W = 16;
`ifdef AHB_GPIO_V2_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [W:0]  GPIOIN;
  logic [W:0]  GPIOOUT;
  logic        PARITYSEL;
  logic        PARITYERR;
  logic        IRQ;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  ahb_gpio_v2 #(.GPIO_W(W), .ADDR_W(32)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .GPIOIN    (GPIOIN),
    .GPIOOUT   (GPIOOUT),
    .PARITYSEL (PARITYSEL),
    .PARITYERR (PARITYERR),
    .IRQ       (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Behavioural model: register file, GPIOIN sample history, pending data phase
  logic [W-1:0] m_out = '0, m_dir = '0, m_ien = '0, m_ist = '0;
  logic         m_sts = 1'b0, m_perr = 1'b0, m_irq = 1'b0;
  logic [W:0]   hist [3] = '{default: '0};
  logic         p_valid = 1'b0, p_write = 1'b0;
  logic [2:0]   p_idx = '0;

  always @(posedge HCLK or negedge HRESETn) begin
    logic         bad;
    logic [W-1:0] set, clr, wd;
    logic         sclr;
    if (!HRESETn) begin
      m_out = '0; m_dir = '0; m_ien = '0; m_ist = '0;
      m_sts = 1'b0; m_perr = 1'b0; m_irq = 1'b0;
      hist = '{default: '0};
      p_valid = 1'b0; p_write = 1'b0; p_idx = '0;
    end else begin
      bad  = (($countones(hist[1]) % 2) == 1) != PARITYSEL;
      set  = HAS_IRQ ? (hist[1][W-1:0] & ~hist[2][W-1:0] & ~m_dir & m_ien) : '0;
      clr  = '0;
      sclr = 1'b0;
      wd   = HWDATA[W-1:0];
      if (p_valid && p_write) begin
        case (p_idx)
          3'd0: m_out = wd;
          3'd2: m_dir = wd;
          3'd3: if (HAS_IRQ) m_ien = wd;
          3'd4: clr = wd;
          3'd5: sclr = HWDATA[0];
          default: ;
        endcase
      end
      m_ist  = (m_ist & ~clr) | set;
      m_sts  = (m_sts & ~sclr) | bad;
      m_perr = bad;
      m_irq  = (m_ist != '0);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = GPIOIN;
      p_valid = HSEL && HREADY && HTRANS[1];
      if (p_valid) begin
        p_write = HWRITE;
        p_idx   = HADDR[4:2];
      end
    end
  end

  function automatic logic [31:0] mread(input logic [2:0] idx);
    case (idx)
      3'd0: return 32'(m_out);
      3'd1: return 32'(hist[1][W-1:0]);
      3'd2: return 32'(m_dir);
      3'd3: return 32'(m_ien);
      3'd4: return 32'(m_ist);
      3'd5: return 32'(m_sts);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mgpioout();
    logic [W-1:0] x;
    logic         p;
    x = m_out & m_dir;
    p = (($countones(x) % 2) == 1) ^ PARITYSEL;
    return 32'({p, x});
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (cmp_en) begin
      checkOutput("HREADYOUT", 32'(HREADYOUT), 32'h1);
      checkOutput("GPIOOUT", 32'(GPIOOUT), mgpioout());
      checkOutput("HRDATA", HRDATA, (p_valid && !p_write) ? mread(p_idx) : 32'h0);
      checkOutput("PARITYERR", 32'(PARITYERR), 32'(m_perr));
      checkOutput("IRQ", 32'(IRQ), 32'(m_irq));
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic applyStimulus(input bit sel, input logic [1:0] trans, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HWDATA = wdata;
    tick();
  endtask

  task automatic busWrite(input logic [4:0] ofs, input logic [31:0] data);
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, {27'd0, ofs}, 32'h0);
    applyStimulus(1'b0, HTRANS_IDLE, 1'b0, 32'h0, data);
  endtask

  task automatic busRead(input logic [4:0] ofs, output logic [31:0] data);
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, {27'd0, ofs}, 32'h0);
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    data = HRDATA;
    tick();
  endtask

  task automatic readCheck(input string name, input logic [4:0] ofs, input logic [31:0] exp);
    logic [31:0] d;
    busRead(ofs, d);
    checkOutput(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    bit          last_acc;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HADDR = '0; HWDATA = '0; HREADY = 1'b1;
    GPIOIN = 17'h10000; PARITYSEL = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    @(negedge HCLK);
    checkOutput("rst_gpioout", 32'(GPIOOUT), 32'h10000);
    checkOutput("rst_irq", 32'(IRQ), 32'h0);
    checkOutput("rst_hrdata", HRDATA, 32'h0);
    tick();
    PARITYSEL = 1'b0;
    GPIOIN = '0;
    HRESETn = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) readCheck("rst_read", 5'(i * 4), 32'h0);

    busWrite(GPIO_DIR_OFS, 32'hFFFF);
    busWrite(GPIO_DATA_OUT_OFS, 32'h00A5);
    @(negedge HCLK);
    checkOutput("gpioout_even", 32'(GPIOOUT), 32'h000A5);
    tick();
    PARITYSEL = 1'b1;
    @(negedge HCLK);
    checkOutput("gpioout_odd", 32'(GPIOOUT), 32'h100A5);
    tick();
    PARITYSEL = 1'b0;
    busWrite(GPIO_DIR_OFS, 32'h000F);
    @(negedge HCLK);
    checkOutput("gpioout_dirmask", 32'(GPIOOUT), 32'h00005);
    tick();

    busWrite(GPIO_STATUS_OFS, 32'h1);
    GPIOIN = 17'h01234;
    tick();
    tick();
    @(negedge HCLK);
    checkOutput("perr_latency", 32'(PARITYERR), 32'h0);
    tick();
    @(negedge HCLK);
    checkOutput("perr_set", 32'(PARITYERR), 32'h1);
    tick();
    readCheck("status_set", GPIO_STATUS_OFS, 32'h1);
    readCheck("data_in", GPIO_DATA_IN_OFS, 32'h1234);
    GPIOIN = 17'h11234;
    repeat (3) tick();
    @(negedge HCLK);
    checkOutput("perr_clear", 32'(PARITYERR), 32'h0);
    tick();
    readCheck("status_sticky", GPIO_STATUS_OFS, 32'h1);
    busWrite(GPIO_STATUS_OFS, 32'h1);
    readCheck("status_w1c", GPIO_STATUS_OFS, 32'h0);

    busWrite(GPIO_DIR_OFS, 32'h0);
`ifdef AHB_GPIO_V2_IRQ_EN
    busWrite(GPIO_IRQ_EN_OFS, 32'h1);
    GPIOIN = '0;
    repeat (3) tick();
    busWrite(GPIO_IRQ_STAT_OFS, 32'hFFFF);
    GPIOIN = 17'h10001;
    repeat (4) tick();
    @(negedge HCLK);
    checkOutput("irq_set", 32'(IRQ), 32'h1);
    tick();
    readCheck("irq_stat_bit0", GPIO_IRQ_STAT_OFS, 32'h1);
    GPIOIN = 17'h00003;
    repeat (4) tick();
    readCheck("irq_stat_masked", GPIO_IRQ_STAT_OFS, 32'h1);
    busWrite(GPIO_IRQ_STAT_OFS, 32'h1);
    @(negedge HCLK);
    checkOutput("irq_clear", 32'(IRQ), 32'h0);
    tick();
`endif

    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, {27'd0, GPIO_DATA_OUT_OFS}, 32'h0);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0;
    HADDR = {27'd0, GPIO_DATA_OUT_OFS}; HWDATA = 32'h5A;
    tick();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    d = HRDATA;
    tick();
    checkOutput("pipelined_wr_rd", d, 32'h5A);
    applyStimulus(1'b1, HTRANS_IDLE, 1'b1, {27'd0, GPIO_DATA_OUT_OFS}, 32'hFFFF);
    applyStimulus(1'b1, HTRANS_IDLE, 1'b1, {27'd0, GPIO_DIR_OFS}, 32'hFFFF);
    applyStimulus(1'b1, HTRANS_BUSY, 1'b1, {27'd0, GPIO_DIR_OFS}, 32'hFFFF);
    applyStimulus(1'b0, HTRANS_NONSEQ, 1'b1, {27'd0, GPIO_DIR_OFS}, 32'hFFFF);
    applyStimulus(1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'hFFFF);
    readCheck("idle_data_out", GPIO_DATA_OUT_OFS, 32'h5A);
    readCheck("idle_dir", GPIO_DIR_OFS, 32'h0);

`ifdef AHB_GPIO_V2_IRQ_EN
    GPIOIN = '0;
    repeat (3) tick();
    GPIOIN = 17'h10001;
    repeat (4) tick();
    GPIOIN = '0;
    repeat (3) tick();
    GPIOIN = 17'h10001;
    tick();
    busWrite(GPIO_IRQ_STAT_OFS, 32'h1);
    readCheck("set_beats_w1c", GPIO_IRQ_STAT_OFS, 32'h1);
`endif

    GPIOIN = '0;
    busWrite(GPIO_DIR_OFS, 32'hFFFF);
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, {27'd0, GPIO_DATA_OUT_OFS}, 32'h0);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'hFFFF;
    #1 HRESETn = 1'b0;
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
    @(negedge HCLK);
    checkOutput("post_rst_gpioout", 32'(GPIOOUT), 32'h0);
    tick();
    readCheck("post_rst_data_out", GPIO_DATA_OUT_OFS, 32'h0);
    readCheck("post_rst_dir", GPIO_DIR_OFS, 32'h0);
    readCheck("post_rst_irq_en", GPIO_IRQ_EN_OFS, 32'h0);
    readCheck("post_rst_irq_stat", GPIO_IRQ_STAT_OFS, 32'h0);
    readCheck("post_rst_status", GPIO_STATUS_OFS, 32'h0);

    last_acc = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      HREADY = last_acc ? 1'b1 : ($urandom_range(3) != 0);
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(3) == 0) GPIOIN = 17'($urandom);
        else GPIOIN = GPIOIN ^ (17'd1 << $urandom_range(W));
      end
      if ($urandom_range(15) == 0) PARITYSEL = ~PARITYSEL;
      a = $urandom;
      a[4:2] = 3'($urandom_range(7));
      applyStimulus($urandom_range(3) != 0, 2'($urandom_range(3)), $urandom_range(1) == 1,
                    a, $urandom);
      last_acc = HSEL && HREADY && HTRANS[1];
    end

    HREADY = 1'b1;
    applyStimulus(1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
